perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
Parametrised successor to the fixed 7-input perceptron. It has N binary inputs and signed W_WIDTH-bit weights held in registers. It classifies each sample against a per-sample signed threshold. When training is enabled, it applies the perceptron learning rule on mistakes, with saturating weight updates. It sits behind the tt_um top-level shell, fed from ui_in/uio_in, and reports classification, mistake flag and a running mistake count.

Parameters:
N_INPUTS, 7, number of binary feature inputs (>=2)
W_WIDTH, 8, signed weight and threshold width (>=3)
ERR_WIDTH, 8, width of saturating mistake counter
ACC_WIDTH (localparam), W_WIDTH+$clog2(N_INPUTS+1), signed accumulator width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_valid  in  1  sample offered
in_ready  out  1  block can accept sample
x  in  N_INPUTS  binary features, bit i gates weight i
exp_res  in  1  expected class (training label)
threshold  in  W_WIDTH  signed threshold, sign-extended to ACC_WIDTH
train  in  1  1 = update weights on mistake, 0 = inference only
out_valid  out  1  one-cycle pulse, result fields valid
result  out  1  classification: acc >= threshold
mistake  out  1  result != exp_res (reported in both modes)
err_count  out  ERR_WIDTH  mistakes counted in train mode only, saturating
err_clr  in  1  clear err_count
wr_en  in  1  direct weight write (IDLE only)
wr_idx  in  $clog2(N_INPUTS)  weight index for write/read
wr_data  in  W_WIDTH  signed weight write value
w_rd  out  W_WIDTH  combinational read of weight[wr_idx]

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, all weights 0, acc 0, result 0, mistake 0, out_valid 0, err_count 0. Reset mid-ACCUM or mid-UPDATE aborts the operation. Partial weight updates are discarded because all weights return to 0.
- in_ready = (state==IDLE) and rst_n==1. in_valid while not ready is ignored (no queuing).
- FSM: IDLE -> ACCUM on in_valid&&in_ready.
  - Accept: latch x, exp_res, sign-extended threshold, train; acc=0, idx=0.
  - ACCUM: one input per cycle, acc += x[idx] ? sext(w[idx]) : 0. Leave after idx=N_INPUTS-1.
  - DECIDE (1 cycle): r = (acc >= thr), signed compare. At the exit edge, register result=r and mistake=(r!=exp), and pulse out_valid.
  - On exit from DECIDE: go to UPDATE if train && mistake, else IDLE.
  - UPDATE: N_INPUTS cycles, one weight per cycle. If x[idx]: w += 1 when exp=1, w -= 1 when exp=0. Saturate to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1]. Weights with x[idx]=0 are unchanged. Then IDLE.
- Latency: out_valid is high in the cycle after edge N_INPUTS+1 counted from the accept edge. Default: 8 cycles after accept.
- Throughput: N+2 cycles per sample without an update, 2N+2 with an update.
- result/mistake hold their value until the next DECIDE exit. out_valid is high for exactly 1 cycle.
- err_count increments at DECIDE exit when train && mistake, and saturates at all-ones.
- err_clr has priority over a simultaneous increment: the result is 0.
- wr_en is honoured only in IDLE, and only when no accept occurs in the same cycle. If in_valid&&wr_en both arrive in IDLE, the accept wins and the write is dropped.
- wr_idx >= N_INPUTS: write is ignored and w_rd returns 0.
- ACC_WIDTH guarantees no accumulator overflow.

Decomposition:
- Package perceptron_pkg:
  - state enum {IDLE, ACCUM, DECIDE, UPDATE}.
  - Functions for ACC_WIDTH computation and W_MAX/W_MIN saturation constants.
- Sub-module perceptron_sat_step (W_WIDTH): combinational signed ±1 saturating adder used in UPDATE.
- Weight storage is a flat register array in the main module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, err_count=0, w_rd=0 for every idx.
- Inference, zero weights: x=7'h7F, threshold=0, train=0, exp=0 -> out_valid exactly 8 cycles after accept, result=1, mistake=1, err_count stays 0, weights unchanged.
- Learning: threshold=1, x=7'b0000011, exp=1, train=1 -> result=0, mistake=1, w0=w1=1, others 0, err_count=1. Repeat the sample -> result=1, mistake=0, err_count=1, next accept 9 cycles later.
- Saturation: write w0=-128, threshold=-128, x=7'b0000001, exp=0, train=1 -> result=1, mistake=1, w0 stays -128. Write w0=127, exp=1, threshold=127 -> result=1, no update.
- Backpressure: pulse in_valid every cycle with changing x -> only samples presented while in_ready=1 are accepted; wr_en during ACCUM leaves the weight unchanged.
- Reset mid-UPDATE: assert rst_n=0 on the 3rd UPDATE cycle -> next cycle state IDLE, all weights 0, err_count=0, out_valid=0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared state encoding and width/saturation helpers for the perceptron trainer
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        UPDATE = 2'd3
    } state_e;

    // Accumulator wide enough to sum N signed weights without overflow.
    function automatic int acc_width(input int n_inputs, input int w_width);
        return w_width + $clog2(n_inputs + 1);
    endfunction

    function automatic int w_max(input int w_width);
        return (1 << (w_width - 1)) - 1;
    endfunction

    function automatic int w_min(input int w_width);
        return -(1 << (w_width - 1));
    endfunction

endpackage

// File: rtl/perceptron_sat_step.sv
// rtl/perceptron_sat_step.sv - combinational signed +/-1 step with saturation at the weight range limits
//   w_i  : current signed weight
//   up_i : 1 = increment, 0 = decrement
//   w_o  : stepped weight, clamped to [W_MIN, W_MAX]
module perceptron_sat_step
    import perceptron_pkg::*;
#(
    parameter int W_WIDTH = 8
) (
    input  logic signed [W_WIDTH-1:0] w_i,
    input  logic                      up_i,
    output logic signed [W_WIDTH-1:0] w_o
);

    localparam logic signed [W_WIDTH-1:0] W_MAX = W_WIDTH'(w_max(W_WIDTH));
    localparam logic signed [W_WIDTH-1:0] W_MIN = W_WIDTH'(w_min(W_WIDTH));

    always_comb begin
        w_o = w_i;
        if (up_i) begin
            if (w_i != W_MAX) begin
                w_o = w_i + W_WIDTH'(1);
            end
        end else if (w_i != W_MIN) begin
            w_o = w_i - W_WIDTH'(1);
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - serial N-input perceptron with on-line training and saturating weights
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : sample handshake (accepted only in IDLE)
//   x, exp_res, threshold : features, training label, signed threshold
//   train                 : 1 = update weights on a mistake
//   out_valid             : one-cycle pulse when result/mistake are refreshed
//   result, mistake       : classification and (result != exp_res)
//   err_count, err_clr    : saturating train-mode mistake counter and its clear
//   wr_en/wr_idx/wr_data  : direct weight write in IDLE; w_rd reads weight[wr_idx]
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS  = 7,
    parameter int W_WIDTH   = 8,
    parameter int ERR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS-1:0]          x,
    input  logic                         exp_res,
    input  logic [W_WIDTH-1:0]           threshold,
    input  logic                         train,
    output logic                         out_valid,
    output logic                         result,
    output logic                         mistake,
    output logic [ERR_WIDTH-1:0]         err_count,
    input  logic                         err_clr,
    input  logic                         wr_en,
    input  logic [$clog2(N_INPUTS)-1:0]  wr_idx,
    input  logic [W_WIDTH-1:0]           wr_data,
    output logic [W_WIDTH-1:0]           w_rd
);

    localparam int ACC_WIDTH = acc_width(N_INPUTS, W_WIDTH);
    localparam int IDX_W     = $clog2(N_INPUTS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  thr_q, thr_d;
    logic [N_INPUTS-1:0]          x_q, x_d;
    logic                         exp_q, exp_d;
    logic                         train_q, train_d;
    logic                         result_q, result_d;
    logic                         mistake_q, mistake_d;
    logic                         out_valid_q, out_valid_d;
    logic [ERR_WIDTH-1:0]         err_q, err_d;
    logic signed [W_WIDTH-1:0]    w_q [N_INPUTS];
    logic signed [W_WIDTH-1:0]    w_d [N_INPUTS];

    logic signed [W_WIDTH-1:0]    cur_w;
    logic signed [W_WIDTH-1:0]    step_w;
    logic                         cur_x;
    logic                         wr_ok;
    logic                         decide_r;

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign mistake   = mistake_q;
    assign err_count = err_q;

    // Indices beyond the populated weights are neither writable nor readable.
    assign wr_ok    = {1'b0, wr_idx} < (IDX_W + 1)'(N_INPUTS);
    assign decide_r = (acc_q >= thr_q);

    // Mux-based selects keep every index in range even when IDX_W covers more
    // codes than there are weights.
    always_comb begin
        cur_w = '0;
        cur_x = 1'b0;
        w_rd  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_w = w_q[i];
                cur_x = x_q[i];
            end
            if (wr_idx == IDX_W'(i)) begin
                w_rd = w_q[i];
            end
        end
    end

    perceptron_sat_step #(
        .W_WIDTH (W_WIDTH)
    ) u_sat_step (
        .w_i  (cur_w),
        .up_i (exp_q),
        .w_o  (step_w)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        thr_d       = thr_q;
        x_d         = x_q;
        exp_d       = exp_q;
        train_d     = train_q;
        result_d    = result_q;
        mistake_d   = mistake_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        w_d         = w_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Accept wins over a same-cycle weight write.
                    x_d     = x;
                    exp_d   = exp_res;
                    thr_d   = {{(ACC_WIDTH - W_WIDTH){threshold[W_WIDTH-1]}}, threshold};
                    train_d = train;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end else if (wr_en && wr_ok) begin
                    for (int i = 0; i < N_INPUTS; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            w_d[i] = wr_data;
                        end
                    end
                end
            end
            ACCUM: begin
                if (cur_x) begin
                    acc_d = acc_q + {{(ACC_WIDTH - W_WIDTH){cur_w[W_WIDTH-1]}}, cur_w};
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DECIDE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DECIDE: begin
                result_d    = decide_r;
                mistake_d   = decide_r ^ exp_q;
                out_valid_d = 1'b1;
                if (train_q && (decide_r ^ exp_q)) begin
                    idx_d   = '0;
                    state_d = UPDATE;
                    if (err_q != '1) begin
                        err_d = err_q + ERR_WIDTH'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    if (cur_x && (idx_q == IDX_W'(i))) begin
                        w_d[i] = step_w;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            thr_q       <= '0;
            x_q         <= '0;
            exp_q       <= 1'b0;
            train_q     <= 1'b0;
            result_q    <= 1'b0;
            mistake_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            thr_q       <= thr_d;
            x_q         <= x_d;
            exp_q       <= exp_d;
            train_q     <= train_d;
            result_q    <= result_d;
            mistake_q   <= mistake_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            for (int i = 0; i < N_INPUTS; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench for perceptron_trainer with a behavioural model
module tb_perceptron_trainer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] x;
    logic       exp_res;
    logic [7:0] threshold;
    logic       train;
    logic       out_valid;
    logic       result;
    logic       mistake;
    logic [7:0] err_count;
    logic       err_clr;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic [7:0] w_rd;

    perceptron_trainer #(
        .N_INPUTS  (7),
        .W_WIDTH   (8),
        .ERR_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .exp_res   (exp_res),
        .threshold (threshold),
        .train     (train),
        .out_valid (out_valid),
        .result    (result),
        .mistake   (mistake),
        .err_count (err_count),
        .err_clr   (err_clr),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .w_rd      (w_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Behavioural model state: plain integer weights and mistake count.
    int w_m [7];
    int err_m;

    typedef struct {
        bit         wr;
        int         widx;
        int         wdata;
        logic [6:0] xv;
        logic       ev;
        int         thr;
        logic       tr;
        logic       r_exp;
        logic       m_exp;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input int act, input int expv);
        check_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    function automatic int dot(input logic [6:0] xv);
        int s = 0;
        for (int i = 0; i < 7; i++) if (xv[i]) s += w_m[i];
        return s;
    endfunction

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) w_m[i] = 0;
        err_m = 0;
    endtask

    task automatic check_weights(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_idx = 3'(i);
            #1;
            chk($sformatf("%s_w%0d", tag, i), int'($signed(w_rd)), (i < 7) ? w_m[i] : 0);
        end
    endtask

    task automatic do_write(input int idx, input int data);
        logic [7:0] d8;
        d8 = data[7:0];
        @(negedge clk);
        wr_en   = 1'b1;
        wr_idx  = 3'(idx);
        wr_data = d8;
        @(negedge clk);
        wr_en = 1'b0;
        if (idx < 7) w_m[idx] = int'($signed(d8));
    endtask

    // Offers one sample, checks timing against the N+2 / 2N+2 rules and the
    // outputs against the model, then advances the model.
    task automatic do_sample(input logic [6:0] xv, input logic ev, input int thr,
                             input logic tr, input logic clr,
                             output logic r_o, output logic m_o);
        int  waited;
        int  ov_cnt;
        int  ov_k;
        int  rdy_k;
        int  s;
        logic r_m;
        logic m_m;
        logic upd;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        x         = xv;
        exp_res   = ev;
        threshold = thr[7:0];
        train     = tr;
        err_clr   = clr;
        in_valid  = 1'b1;
        @(posedge clk);
        s   = dot(xv);
        r_m = (s >= thr);
        m_m = (r_m != ev);
        upd = tr && m_m;
        ov_cnt = 0;
        ov_k   = -1;
        rdy_k  = -1;
        r_o    = 1'b0;
        m_o    = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
            if (out_valid) begin
                ov_cnt++;
                if (ov_k < 0) ov_k = k;
                r_o = result;
                m_o = mistake;
            end
            if (k > 0 && in_ready) begin
                rdy_k = k;
                break;
            end
        end
        err_clr = 1'b0;
        chk("latency", ov_k, 8);
        chk("out_valid_pulses", ov_cnt, 1);
        chk("ready_after", rdy_k, upd ? 15 : 8);
        chk("result_model", int'(r_o), int'(r_m));
        chk("mistake_model", int'(m_o), int'(m_m));
        if (upd) begin
            for (int i = 0; i < 7; i++)
                if (xv[i]) w_m[i] = clamp(w_m[i] + (ev ? 1 : -1));
        end
        if (clr) err_m = 0;
        else if (upd && err_m < 255) err_m++;
        chk("err_count", int'(err_count), err_m);
    endtask

    logic       r_got;
    logic       m_got;
    logic [6:0] bp_x [37];
    int         exp_q [$];
    int         got_q [$];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        exp_res   = 1'b0;
        threshold = '0;
        train     = 1'b0;
        err_clr   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        model_reset();

        tbl[0] = '{0, 0,    0, 7'h7F, 1'b0,    0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{0, 0,    0, 7'h03, 1'b1,    1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{0, 0,    0, 7'h03, 1'b1,    1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1, 0, -128, 7'h01, 1'b0, -128, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1, 0,  127, 7'h01, 1'b1,  127, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_mistake", int'(mistake), 0);
        check_weights("rst");

        // Directed table
        for (int t = 0; t < 5; t++) begin
            if (tbl[t].wr) do_write(tbl[t].widx, tbl[t].wdata);
            do_sample(tbl[t].xv, tbl[t].ev, tbl[t].thr, tbl[t].tr, 1'b0, r_got, m_got);
            chk($sformatf("tbl%0d_result", t), int'(r_got), int'(tbl[t].r_exp));
            chk($sformatf("tbl%0d_mistake", t), int'(m_got), int'(tbl[t].m_exp));
            check_weights($sformatf("tbl%0d", t));
        end

        // Out-of-range write index is ignored and reads back 0
        do_write(7, 8'h5A);
        check_weights("oob");

        // Backpressure: in_valid and wr_en held high every cycle
        for (int i = 0; i < 7; i++) do_write(i, int'($urandom_range(40)) - 20);
        for (int c = 0; c < 37; c++) bp_x[c] = 7'($urandom);
        for (int c = 0; c < 36; c += 9) exp_q.push_back(int'(dot(bp_x[c]) >= 0));
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c > 0 && out_valid) got_q.push_back(int'(result));
            if (c < 36) begin
                in_valid  = 1'b1;
                x         = bp_x[c];
                exp_res   = 1'b0;
                threshold = 8'h00;
                train     = 1'b0;
                wr_en     = 1'b1;
                wr_idx    = 3'd0;
                wr_data   = 8'h55;
            end else begin
                in_valid = 1'b0;
                wr_en    = 1'b0;
            end
        end
        chk("bp_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("bp_result%0d", i), got_q[i], exp_q[i]);
        check_weights("bp");

        // Randomized samples against the model
        for (int n = 0; n < 30; n++) begin
            if (n % 6 == 0) do_write(int'($urandom_range(6)), ($urandom_range(3) == 0) ? -128 : 127);
            else if (n % 3 == 0) do_write(int'($urandom_range(7)), int'($urandom_range(40)) - 20);
            do_sample(7'($urandom), 1'($urandom), int'($urandom_range(60)) - 30,
                      1'($urandom), 1'b0, r_got, m_got);
            if (n % 5 == 4) check_weights($sformatf("rnd%0d", n));
        end

        // Mistake counter saturation, then clear vs simultaneous increment
        for (int n = 0; n < 260; n++)
            do_sample(7'h00, 1'b1, 1, 1'b1, 1'b0, r_got, m_got);
        chk("err_sat", int'(err_count), 255);
        do_sample(7'h00, 1'b1, 1, 1'b1, 1'b1, r_got, m_got);
        chk("err_clr_prio", int'(err_count), 0);
        do_sample(7'h00, 1'b1, 1, 1'b1, 1'b0, r_got, m_got);

        // Reset on the third UPDATE cycle
        for (int i = 0; i < 7; i++) do_write(i, -5);
        @(negedge clk);
        x         = 7'h7F;
        exp_res   = 1'b1;
        threshold = 8'd1;
        train     = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            if (j == 0) in_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_err", int'(err_count), 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        model_reset();
        check_weights("midrst");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
